// File: rtl/filter_stream_feeder.sv
// Paced sample feeder for the integrator/differentiator filter.
// Buffers upstream samples and owns the filter mode line.
module filter_stream_feeder #(
  parameter int DATA_WIDTH = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int RATE_DIV   = 4,
  parameter int FLUSH_LEN  = 12
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          mode_req,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          filt_ctrl,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pacer_q, pacer_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic                  target_q, target_d;
  logic                  ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  mv_q, mv_d;
  logic [DATA_WIDTH-1:0] md_q, md_d;
  logic [LW-1:0]         level_q, level_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic slot, empty, full, push, pop;

  assign slot  = (pacer_q == PW'(RATE_DIV - 1));
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));
  // held low while reset is asserted, not only after it
  assign s_tready = arst_n && (state_q == ST_RUN) && !full;
  assign push  = s_tvalid && s_tready;
  assign pop   = slot && !empty && (state_q != ST_FLUSH);

  always_comb begin
    state_d  = state_q;
    pacer_d  = slot ? '0 : pacer_q + 1'b1;
    flush_d  = flush_q;
    target_d = target_q;
    ctrl_d   = ctrl_q;
    mv_d     = 1'b0;
    md_d     = md_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    level_d  = level_q;

    if (push) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d = rd_q + 1'b1;
      md_d = mem_q[rd_q];
      mv_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    unique case (state_q)
      ST_RUN: begin
        if (mode_req != ctrl_q) begin
          state_d  = ST_DRAIN;
          target_d = mode_req;
        end
      end
      ST_DRAIN: begin
        // wait until the last data strobe is gone before switching mode
        if (empty && !mv_q) begin
          state_d = ST_FLUSH;
          ctrl_d  = target_q;
          flush_d = '0;
        end
      end
      ST_FLUSH: begin
        if (slot) begin
          md_d    = '0;
          mv_d    = 1'b1;
          flush_d = flush_q + 1'b1;
          if (flush_q == FW'(FLUSH_LEN - 1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_RUN;
      pacer_q  <= '0;
      flush_q  <= '0;
      target_q <= 1'b0;
      ctrl_q   <= 1'b0;
      busy_q   <= 1'b0;
      mv_q     <= 1'b0;
      md_q     <= '0;
      level_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pacer_q  <= pacer_d;
      flush_q  <= flush_d;
      target_q <= target_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      mv_q     <= mv_d;
      md_q     <= md_d;
      level_q  <= level_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_tdata;
  end

  assign m_tdata    = md_q;
  assign m_tvalid   = mv_q;
  assign filt_ctrl  = ctrl_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule
